// File: rtl/cmp_run_pulse_fsm.sv
// rtl/cmp_run_pulse_fsm.sv - compare-run detector emitting a fixed-length Moore pulse with event counter
module cmp_run_pulse_fsm #(
  parameter int WIDTH            = 4,
  parameter int RUN_LEN          = 3,
  parameter int PULSE_LEN        = 2,
  parameter int REARM_ON_RELEASE = 1,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             clr_cnt,
  output logic             y_out,
  output logic             busy,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int RUN_W   = $clog2(RUN_LEN + 1);
  localparam int PULSE_W = $clog2(PULSE_LEN + 1);

  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(RUN_LEN - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  // Encoding 2'd3 is unused and steers back to ARM.
  typedef enum logic [1:0] {
    ARM   = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [RUN_W-1:0]   run_cnt, run_cnt_d;
  logic [PULSE_W-1:0] pulse_cnt, pulse_cnt_d;
  logic               cond;
  logic               fire;

  // Relation between the operands selected by mode (unsigned compares).
  always_comb begin
    cond = 1'b0;
    case (mode)
      2'b00:   cond = (x1 == x2);
      2'b01:   cond = (x1 != x2);
      2'b10:   cond = (x1 > x2);
      default: cond = (x1 < x2);
    endcase
  end

  // Next-state logic: qualify runs in ARM, time the pulse, hold in WAIT until release.
  always_comb begin
    state_d     = state;
    run_cnt_d   = run_cnt;
    pulse_cnt_d = pulse_cnt;
    fire        = 1'b0;
    case (state)
      ARM: begin
        pulse_cnt_d = '0;
        if (!(en && cond)) begin
          run_cnt_d = '0;
        end else if (run_cnt == RUN_LAST) begin
          state_d   = PULSE;
          run_cnt_d = '0;
          fire      = 1'b1;
        end else begin
          run_cnt_d = run_cnt + RUN_W'(1);
        end
      end
      PULSE: begin
        run_cnt_d = '0;
        if (pulse_cnt == PULSE_LAST) begin
          pulse_cnt_d = '0;
          state_d     = (REARM_ON_RELEASE != 0) ? WAIT : ARM;
        end else begin
          pulse_cnt_d = pulse_cnt + PULSE_W'(1);
        end
      end
      WAIT: begin
        run_cnt_d   = '0;
        pulse_cnt_d = '0;
        if (!(en && cond)) begin
          state_d = ARM;
        end
      end
      default: begin
        state_d     = ARM;
        run_cnt_d   = '0;
        pulse_cnt_d = '0;
      end
    endcase
  end

  // State, counters and the saturating event counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARM;
      run_cnt   <= '0;
      pulse_cnt <= '0;
      event_cnt <= '0;
    end else begin
      state     <= state_d;
      run_cnt   <= run_cnt_d;
      pulse_cnt <= pulse_cnt_d;
      if (clr_cnt) begin
        event_cnt <= '0;
      end else if (fire && (event_cnt != CNT_MAX)) begin
        event_cnt <= event_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs decode only the registered state.
  always_comb begin
    y_out = (state == PULSE);
    busy  = (state == PULSE) || (state == WAIT);
  end

endmodule

// File: tb/tb_cmp_run_pulse_fsm.sv
// tb/tb_cmp_run_pulse_fsm.sv - bench for cmp_run_pulse_fsm in default, legacy and small-counter configurations
module tb_cmp_run_pulse_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [3:0] x1 = 4'd5;
  logic [3:0] x2 = 4'd5;
  logic       clr_cnt = 1'b0;

  logic       y0, y1, y2;
  logic       b0, b1, b2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: legacy detector. Instance 2: fast events, 2-bit counter.
  cmp_run_pulse_fsm #(.WIDTH(4), .RUN_LEN(3), .PULSE_LEN(2), .REARM_ON_RELEASE(1), .CNT_W(8)) u_def (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x1(x1), .x2(x2), .clr_cnt(clr_cnt),
    .y_out(y0), .busy(b0), .event_cnt(c0));

  cmp_run_pulse_fsm #(.WIDTH(1), .RUN_LEN(1), .PULSE_LEN(1), .REARM_ON_RELEASE(0), .CNT_W(8)) u_leg (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x1(x1[0:0]), .x2(x2[0:0]), .clr_cnt(clr_cnt),
    .y_out(y1), .busy(b1), .event_cnt(c1));

  cmp_run_pulse_fsm #(.WIDTH(4), .RUN_LEN(1), .PULSE_LEN(1), .REARM_ON_RELEASE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .x1(x1), .x2(x2), .clr_cnt(clr_cnt),
    .y_out(y2), .busy(b2), .event_cnt(c2));

  int p_run[3]   = '{3, 1, 1};
  int p_plen[3]  = '{2, 1, 1};
  int p_rearm[3] = '{1, 0, 0};
  int p_cmax[3]  = '{255, 255, 3};
  int p_mask[3]  = '{15, 1, 15};

  int m_streak[3] = '{0, 0, 0};
  int m_left[3]   = '{0, 0, 0};
  int m_wait[3]   = '{0, 0, 0};
  int m_cnt[3]    = '{0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: streak length, remaining pulse cycles, waiting-for-release flag.
  always @(posedge clk) begin : model_step
    int a, b, c, fire;
    for (int i = 0; i < 3; i++) begin
      a = int'(x1) & p_mask[i];
      b = int'(x2) & p_mask[i];
      case (mode)
        2'b00:   c = (a == b) ? 1 : 0;
        2'b01:   c = (a != b) ? 1 : 0;
        2'b10:   c = (a > b) ? 1 : 0;
        default: c = (a < b) ? 1 : 0;
      endcase
      fire = 0;
      if (rst) begin
        m_streak[i] = 0;
        m_left[i]   = 0;
        m_wait[i]   = 0;
        m_cnt[i]    = 0;
      end else begin
        if (m_left[i] > 0) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0 && p_rearm[i] != 0) m_wait[i] = 1;
        end else if (m_wait[i] != 0) begin
          if (!(en && c != 0)) m_wait[i] = 0;
        end else if (en && c != 0) begin
          m_streak[i] = m_streak[i] + 1;
          if (m_streak[i] == p_run[i]) begin
            fire        = 1;
            m_streak[i] = 0;
            m_left[i]   = p_plen[i];
          end
        end else begin
          m_streak[i] = 0;
        end
        if (clr_cnt) m_cnt[i] = 0;
        else if (fire != 0 && m_cnt[i] < p_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  // Every-cycle comparison of all instances against the reference.
  always @(negedge clk) begin
    check("y_def",   int'(y0), (m_left[0] > 0) ? 1 : 0);
    check("busy_def", int'(b0), (m_left[0] > 0 || m_wait[0] != 0) ? 1 : 0);
    check("cnt_def", int'(c0), m_cnt[0]);
    check("y_leg",   int'(y1), (m_left[1] > 0) ? 1 : 0);
    check("busy_leg", int'(b1), (m_left[1] > 0 || m_wait[1] != 0) ? 1 : 0);
    check("cnt_leg", int'(c1), m_cnt[1]);
    check("y_sat",   int'(y2), (m_left[2] > 0) ? 1 : 0);
    check("busy_sat", int'(b2), (m_left[2] > 0 || m_wait[2] != 0) ? 1 : 0);
    check("cnt_sat", int'(c2), m_cnt[2]);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    // Reset, then interrupt the first pulse with another reset.
    tick(1);
    rst = 1'b0;
    check("lit_reset_y", int'(y0), 0);
    check("lit_reset_cnt", int'(c0), 0);
    tick(2);
    check("lit_run2_y", int'(y0), 0);
    tick(1);
    check("lit_run3_y", int'(y0), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("lit_midrst_y", int'(y0), 0);
    check("lit_midrst_busy", int'(b0), 0);
    check("lit_midrst_cnt", int'(c0), 0);

    // Broken run under EQ.
    do_reset();
    mode = 2'b00; x1 = 4'd3; x2 = 4'd3;
    tick(2);
    x2 = 4'd4;
    tick(1);
    check("lit_broken_y", int'(y0), 0);
    x2 = 4'd3;
    tick(2);
    check("lit_rerun2_y", int'(y0), 0);
    tick(1);
    check("lit_rerun3_y", int'(y0), 1);
    check("lit_rerun_cnt", int'(c0), 1);
    tick(1);
    check("lit_pulse2_y", int'(y0), 1);
    tick(1);
    check("lit_pulse_end_y", int'(y0), 0);
    check("lit_wait_busy", int'(b0), 1);

    // Re-arm on release under GT.
    do_reset();
    mode = 2'b10; x1 = 4'd9; x2 = 4'd2;
    tick(12);
    check("lit_gt_hold_y", int'(y0), 0);
    check("lit_gt_hold_busy", int'(b0), 1);
    check("lit_gt_hold_cnt", int'(c0), 1);
    x1 = 4'd2;
    tick(1);
    check("lit_gt_release_busy", int'(b0), 0);
    x1 = 4'd9;
    tick(2);
    check("lit_gt_restore2_y", int'(y0), 0);
    tick(1);
    check("lit_gt_restore3_y", int'(y0), 1);
    check("lit_gt_restore_cnt", int'(c0), 2);

    // en gating under NE.
    do_reset();
    mode = 2'b01; x1 = 4'd1; x2 = 4'd0;
    en = 1'b1; tick(1);
    en = 1'b1; tick(1);
    en = 1'b0; tick(1);
    en = 1'b1; tick(1);
    en = 1'b1; tick(1);
    check("lit_ne_gap_y", int'(y0), 0);
    en = 1'b1; tick(1);
    check("lit_ne_fire_y", int'(y0), 1);
    en = 1'b0;
    tick(3);
    en = 1'b1;

    // LT true and false.
    do_reset();
    mode = 2'b11; x1 = 4'd0; x2 = 4'd15;
    tick(3);
    check("lit_lt_true_y", int'(y0), 1);
    do_reset();
    x1 = 4'd15; x2 = 4'd0;
    tick(6);
    check("lit_lt_false_busy", int'(b0), 0);
    check("lit_lt_false_cnt", int'(c0), 0);

    // Legacy two-state behaviour.
    do_reset();
    mode = 2'b00; x1 = 4'd1; x2 = 4'd0;
    tick(1);
    check("lit_leg_ne_y", int'(y1), 0);
    x2 = 4'd1;
    tick(1); check("lit_leg_y1", int'(y1), 1);
    tick(1); check("lit_leg_y2", int'(y1), 0);
    tick(1); check("lit_leg_y3", int'(y1), 1);
    tick(1); check("lit_leg_y4", int'(y1), 0);

    // Counter saturation and clear-versus-increment.
    do_reset();
    mode = 2'b00; x1 = 4'd7; x2 = 4'd7;
    tick(10);
    check("lit_sat_cnt", int'(c2), 3);
    check("lit_sat_y", int'(y2), 0);
    clr_cnt = 1'b1;
    tick(1);
    check("lit_clr_cnt", int'(c2), 0);
    check("lit_clr_y", int'(y2), 1);
    clr_cnt = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
